clkroot_div: RTL and testbench

Glitch-free, runtime-programmable integer clock divider that generates a system clock root from the reference clock. Its output is a flop output and drives the clock root anchor buffer directly, so the divided clock is never derived from combinational logic. Divisor changes are buffered and applied only at a full output period boundary, so no runt pulses appear on the root. Divisor 0 or 1 parks the output low.

---
 rtl/clkroot_div.sv | 110 +++++++++++
 tb/tb_clkroot_div.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clkroot_div.sv
// Glitch-free runtime-programmable integer clock divider for the system clock root.
// The divided clock is a flop output; divisor changes are applied only at a period boundary.
module clkroot_div #(
    parameter int unsigned W_DIV     = 8,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_DIV-1:0] div_wdata,
    input  logic             div_wen,
    output logic             div_busy,
    output logic [W_DIV-1:0] div_cur,
    output logic             clk_out,
    output logic             clk_rise,
    output logic             running
);

    localparam logic [W_DIV-1:0] DivReset = W_DIV'(DIV_RESET);
    // Starting on the last count makes the first edge after reset a boundary.
    localparam logic [W_DIV-1:0] CtrReset = (DIV_RESET >= 2) ? W_DIV'(DIV_RESET - 1) : '0;

    logic [W_DIV-1:0] r_ctr,      w_ctr_d;
    logic [W_DIV-1:0] r_cur_div,  w_cur_div_d;
    logic [W_DIV-1:0] r_pend_div, w_pend_div_d;
    logic             r_pend_vld, w_pend_vld_d;
    logic             r_clk_out,  w_clk_out_d;
    logic             r_clk_rise, w_clk_rise_d;

    logic [W_DIV:0]   w_high;
    logic [W_DIV:0]   w_ctr_inc;
    logic             w_running;
    logic             w_boundary;
    logic             w_pend_runs;

    always_comb begin
        w_high      = ({1'b0, r_cur_div} + (W_DIV+1)'(1)) >> 1;
        w_ctr_inc   = {1'b0, r_ctr} + (W_DIV+1)'(1);
        w_running   = (r_cur_div >= W_DIV'(2));
        w_boundary  = w_running && (r_ctr == (r_cur_div - W_DIV'(1)));
        w_pend_runs = (r_pend_div >= W_DIV'(2));
    end

    always_comb begin
        w_ctr_d      = r_ctr;
        w_cur_div_d  = r_cur_div;
        w_pend_div_d = r_pend_div;
        w_pend_vld_d = r_pend_vld;
        w_clk_out_d  = r_clk_out;
        w_clk_rise_d = 1'b0;

        if (w_running) begin
            if (w_boundary) begin
                w_ctr_d      = '0;
                w_clk_out_d  = 1'b1;
                w_clk_rise_d = 1'b1;
                if (r_pend_vld) begin
                    w_cur_div_d  = r_pend_div;
                    w_pend_vld_d = 1'b0;
                    if (!w_pend_runs) begin
                        w_clk_out_d  = 1'b0;
                        w_clk_rise_d = 1'b0;
                    end
                end
            end else begin
                w_ctr_d     = w_ctr_inc[W_DIV-1:0];
                w_clk_out_d = (w_ctr_inc < w_high);
            end
        end else begin
            w_ctr_d     = '0;
            w_clk_out_d = 1'b0;
            if (r_pend_vld) begin
                w_cur_div_d  = r_pend_div;
                w_pend_vld_d = 1'b0;
                w_clk_out_d  = w_pend_runs;
                w_clk_rise_d = w_pend_runs;
            end
        end

        // A write on the apply edge stays pending for the next boundary.
        if (div_wen) begin
            w_pend_div_d = div_wdata;
            w_pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctr      <= CtrReset;
            r_cur_div  <= DivReset;
            r_pend_div <= '0;
            r_pend_vld <= 1'b0;
            r_clk_out  <= 1'b0;
            r_clk_rise <= 1'b0;
        end else begin
            r_ctr      <= w_ctr_d;
            r_cur_div  <= w_cur_div_d;
            r_pend_div <= w_pend_div_d;
            r_pend_vld <= w_pend_vld_d;
            r_clk_out  <= w_clk_out_d;
            r_clk_rise <= w_clk_rise_d;
        end
    end

    assign div_busy = r_pend_vld;
    assign div_cur  = r_cur_div;
    assign clk_out  = r_clk_out;
    assign clk_rise = r_clk_rise;
    assign running  = (r_cur_div >= W_DIV'(2));

endmodule

// File: tb/tb_clkroot_div.sv
// Directed table-driven bench for clkroot_div with W_DIV=8, DIV_RESET=2.
// Each vector drives inputs before an edge and checks the registered outputs just after it.
module tb_clkroot_div;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] div_wdata;
    logic         div_wen;
    logic         div_busy;
    logic [W-1:0] div_cur;
    logic         clk_out;
    logic         clk_rise;
    logic         running;

    int n_checks = 0;
    int n_fail   = 0;

    clkroot_div #(
        .W_DIV     (W),
        .DIV_RESET (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_wdata (div_wdata),
        .div_wen   (div_wen),
        .div_busy  (div_busy),
        .div_cur   (div_cur),
        .clk_out   (clk_out),
        .clk_rise  (clk_rise),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         wen;
        logic [W-1:0] wdata;
        logic         out;
        logic         rise;
        logic         busy;
        logic [W-1:0] cur;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic we, input int wd, input logic o,
                       input logic ri, input logic b, input int c);
        vec_t v;
        v.rst_n = r;
        v.wen   = we;
        v.wdata = W'(wd);
        v.out   = o;
        v.rise  = ri;
        v.busy  = b;
        v.cur   = W'(c);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [W-1:0] wd);
        rst_n     = r;
        div_wen   = we;
        div_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic o, input logic ri, input logic b,
                           input logic [W-1:0] c);
        chk("clk_out", idx, int'(clk_out), int'(o));
        chk("clk_rise", idx, int'(clk_rise), int'(ri));
        chk("div_busy", idx, int'(div_busy), int'(b));
        chk("div_cur", idx, int'(div_cur), int'(c));
        chk("running", idx, int'(running), int'(c >= 2));
    endtask

    initial begin
        int waited;
        int idx;

        // N=2 out of reset: toggles every cycle, rise follows clk_out
        add(1, 0, 0, 1, 1, 0, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 1, 1, 0, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 1, 1, 0, 2);
        // write 5 at ctr=0, applied at end of N=2 period, then high 3 / low 2
        add(1, 1, 5, 0, 0, 1, 2);
        add(1, 0, 0, 1, 1, 0, 5);
        add(1, 0, 0, 1, 0, 0, 5);
        add(1, 0, 0, 1, 0, 0, 5);
        add(1, 0, 0, 0, 0, 0, 5);
        add(1, 0, 0, 0, 0, 0, 5);
        add(1, 0, 0, 1, 1, 0, 5);
        // write 7 then 4: only 4 applied, high 2 / low 2
        add(1, 1, 7, 1, 0, 1, 5);
        add(1, 1, 4, 1, 0, 1, 5);
        add(1, 0, 0, 0, 0, 1, 5);
        add(1, 0, 0, 0, 0, 1, 5);
        add(1, 0, 0, 1, 1, 0, 4);
        add(1, 0, 0, 1, 0, 0, 4);
        add(1, 0, 0, 0, 0, 0, 4);
        add(1, 0, 0, 0, 0, 0, 4);
        add(1, 0, 0, 1, 1, 0, 4);
        // switch to 6
        add(1, 1, 6, 1, 0, 1, 4);
        add(1, 0, 0, 0, 0, 1, 4);
        add(1, 0, 0, 0, 0, 1, 4);
        add(1, 0, 0, 1, 1, 0, 6);
        // write 0 at N=6: finish 3 high / 3 low then park low
        add(1, 1, 0, 1, 0, 1, 6);
        add(1, 0, 0, 1, 0, 1, 6);
        add(1, 0, 0, 0, 0, 1, 6);
        add(1, 0, 0, 0, 0, 1, 6);
        add(1, 0, 0, 0, 0, 1, 6);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        // write 3 while stopped: captured, applied next edge, high 2 / low 1
        add(1, 1, 3, 0, 0, 1, 0);
        add(1, 0, 0, 1, 1, 0, 3);
        add(1, 0, 0, 1, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 1, 1, 0, 3);
        // go to 9, then reset mid-high with 4 pending
        add(1, 1, 9, 1, 0, 1, 3);
        add(1, 0, 0, 0, 0, 1, 3);
        add(1, 0, 0, 1, 1, 0, 9);
        add(1, 1, 4, 1, 0, 1, 9);
        add(1, 0, 0, 1, 0, 1, 9);
        add(0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 1, 1, 0, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 1, 1, 0, 2);
        // write on the boundary edge: 5 applied, 3 stays pending
        add(1, 1, 5, 0, 0, 1, 2);
        add(1, 1, 3, 1, 1, 1, 5);
        add(1, 0, 0, 1, 0, 1, 5);
        add(1, 0, 0, 1, 0, 1, 5);
        add(1, 0, 0, 0, 0, 1, 5);
        add(1, 0, 0, 0, 0, 1, 5);
        add(1, 0, 0, 1, 1, 0, 3);

        step(0, 0, '0);
        step(0, 0, '0);
        chk_all(-1, 0, 0, 0, 2);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].wen, vecs[i].wdata);
            chk_all(i, vecs[i].out, vecs[i].rise, vecs[i].busy, vecs[i].cur);
        end

        // N=255: three periods of 128 high / 127 low, one rise per period
        step(1, 1, 8'd255);
        waited = 0;
        while (!(clk_rise && div_cur == 8'd255) && waited < 20) begin
            step(1, 0, '0);
            waited++;
        end
        chk("n255_apply_timeout", waited, int'(waited < 20), 1);
        idx = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 255; c++) begin
                if (c != 0) step(1, 0, '0);
                chk("n255_out", idx, int'(clk_out), int'(c < 128));
                chk("n255_rise", idx, int'(clk_rise), int'(c == 0));
                idx++;
            end
            step(1, 0, '0);
            chk("n255_period_end", p, int'(clk_rise), 1);
            idx++;
            if (p != 2) begin
                chk("n255_out", idx, int'(clk_out), 1);
            end
        end
        chk("n255_div_cur", 0, int'(div_cur), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
